sc_pulse_train_gen: RTL and testbench

//  Programmable pulse-train generator: emits exactly COUNT pulses of PERIOD clock cycles each, then flags completion.

---
 rtl/sc_pulse_train_gen_if.sv | 22 ++
 rtl/sc_pulse_train_gen.sv | 78 +++++++
 tb/tb_sc_pulse_train_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_pulse_train_gen_if.sv
// sc_pulse_train_gen_if: start/abort handshake, train setup and status lines of the pulse-train generator.
interface sc_pulse_train_gen_if #(
   parameter int N = 8,
   parameter int P = 16
);
   logic         SC_PULSETRAIN_START_InLow;
   logic         SC_PULSETRAIN_ABORT_InLow;
   logic [N-1:0] SC_PULSETRAIN_COUNT;
   logic [P-1:0] SC_PULSETRAIN_PERIOD;
   logic         SC_PULSETRAIN_PULSE_Out;
   logic         SC_PULSETRAIN_BUSY_OutLow;
   logic         SC_PULSETRAIN_DONE_OutLow;
   logic [N-1:0] SC_PULSETRAIN_REMAINING;
   modport master (
      output SC_PULSETRAIN_START_InLow, SC_PULSETRAIN_ABORT_InLow, SC_PULSETRAIN_COUNT, SC_PULSETRAIN_PERIOD,
      input  SC_PULSETRAIN_PULSE_Out, SC_PULSETRAIN_BUSY_OutLow, SC_PULSETRAIN_DONE_OutLow, SC_PULSETRAIN_REMAINING
   );
   modport slave (
      input  SC_PULSETRAIN_START_InLow, SC_PULSETRAIN_ABORT_InLow, SC_PULSETRAIN_COUNT, SC_PULSETRAIN_PERIOD,
      output SC_PULSETRAIN_PULSE_Out, SC_PULSETRAIN_BUSY_OutLow, SC_PULSETRAIN_DONE_OutLow, SC_PULSETRAIN_REMAINING
   );
endinterface

// File: rtl/sc_pulse_train_gen.sv
// sc_pulse_train_gen: emits COUNT pulses of PERIOD cycles each, then strobes DONE for one cycle.
// Define PULSETRAIN_CONTINUOUS_EN to make COUNT==0 start an endless train.
module sc_pulse_train_gen #(
   parameter int N = 8,
   parameter int P = 16
) (
   input logic                 SC_PULSETRAIN_CLOCK,
   input logic                 SC_PULSETRAIN_RESET_InHigh,
   sc_pulse_train_gen_if.slave bus_if
);
`ifdef PULSETRAIN_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
   state_t       state_q, state_d;
   logic [N-1:0] rem_q, rem_d;
   logic [P-1:0] cnt_q, cnt_d, hm1_q, hm1_d, lm1_q, lm1_d, t, h;
   logic         cont_q, cont_d;
   always_ff @(posedge SC_PULSETRAIN_CLOCK or posedge SC_PULSETRAIN_RESET_InHigh)
      if (SC_PULSETRAIN_RESET_InHigh) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         hm1_q   <= '0;
         lm1_q   <= '0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         hm1_q   <= hm1_d;
         lm1_q   <= lm1_d;
         cont_q  <= cont_d;
      end
   // Phase limits are stored as H-1 / L-1 so the phase counter compares directly.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      hm1_d   = hm1_q;
      lm1_d   = lm1_q;
      cont_d  = cont_q;
      t       = bus_if.SC_PULSETRAIN_PERIOD < P'(2) ? P'(2) : bus_if.SC_PULSETRAIN_PERIOD;
      h       = t >> 1;
      if (!bus_if.SC_PULSETRAIN_ABORT_InLow) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else
         case (state_q)
            IDLE: if (!bus_if.SC_PULSETRAIN_START_InLow) begin
               rem_d   = bus_if.SC_PULSETRAIN_COUNT;
               hm1_d   = h - 1'b1;
               lm1_d   = t - h - 1'b1;
               cnt_d   = '0;
               cont_d  = CONT && bus_if.SC_PULSETRAIN_COUNT == '0;
               state_d = (bus_if.SC_PULSETRAIN_COUNT != '0 || cont_d) ? HIGH : DONE;
            end
            HIGH: if (cnt_q == hm1_q) begin
               cnt_d   = '0;
               state_d = LOW;
               rem_d   = cont_q ? rem_q : rem_q - 1'b1;
            end else
               cnt_d = cnt_q + 1'b1;
            LOW: if (cnt_q == lm1_q) begin
               cnt_d   = '0;
               state_d = (cont_q || rem_q != '0) ? HIGH : DONE;
            end else
               cnt_d = cnt_q + 1'b1;
            DONE: state_d = IDLE;
         endcase
   end
   assign bus_if.SC_PULSETRAIN_PULSE_Out   = state_q == HIGH;
   assign bus_if.SC_PULSETRAIN_BUSY_OutLow = state_q == IDLE;
   assign bus_if.SC_PULSETRAIN_DONE_OutLow = state_q != DONE;
   assign bus_if.SC_PULSETRAIN_REMAINING   = rem_q;
endmodule

// File: tb/tb_sc_pulse_train_gen.sv
// tb_sc_pulse_train_gen: checks the pulse-train generator against a timeline model of each train.
module tb_sc_pulse_train_gen;
   localparam int N = 8;
   localparam int P = 16;
`ifdef PULSETRAIN_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   sc_pulse_train_gen_if #(.N(N), .P(P)) bif ();
   sc_pulse_train_gen #(.N(N), .P(P)) dut (
      .SC_PULSETRAIN_CLOCK       (clk),
      .SC_PULSETRAIN_RESET_InHigh(rst),
      .bus_if                    (bif)
   );
   always #5 clk = ~clk;
   int           n_chk = 0;
   int           n_pass = 0;
   int           cyc = 0;
   bit           m_act = 1'b0;
   bit           m_cont = 1'b0;
   int           m_s = 0;
   int           m_c = 0;
   int           m_t = 2;
   logic [N-1:0] m_rem = '0;
   logic [N+2:0] e_vec = {3'b011, {N{1'b0}}};
   // {PULSE, BUSY_n, DONE_n, REMAINING}
   function automatic logic [N+2:0] obs();
      return {bif.SC_PULSETRAIN_PULSE_Out, bif.SC_PULSETRAIN_BUSY_OutLow,
              bif.SC_PULSETRAIN_DONE_OutLow, bif.SC_PULSETRAIN_REMAINING};
   endfunction
   // Cycle k of a train: pulse i=k/T occupies k in [i*T, i*T+T), high for the first T/2 of it.
   function automatic void model_eval();
      int k, h, ph, i;
      if (!m_act) e_vec = {3'b011, m_rem};
      else begin
         k  = cyc - m_s;
         h  = m_t / 2;
         ph = k % m_t;
         i  = k / m_t;
         if (m_cont) e_vec = {ph < h, 2'b01, N'(0)};
         else if (k == m_c * m_t) e_vec = '0;
         else e_vec = {ph < h, 2'b01, N'(m_c - i - (ph >= h ? 1 : 0))};
      end
   endfunction
   task automatic tick();
      if (m_act && (!bif.SC_PULSETRAIN_ABORT_InLow || (!m_cont && cyc - m_s == m_c * m_t))) begin
         m_act = 1'b0;
         m_rem = e_vec[N-1:0];
      end else if (!m_act && bif.SC_PULSETRAIN_ABORT_InLow && !bif.SC_PULSETRAIN_START_InLow) begin
         m_act  = 1'b1;
         m_s    = cyc + 1;
         m_c    = int'(bif.SC_PULSETRAIN_COUNT);
         m_t    = bif.SC_PULSETRAIN_PERIOD < 2 ? 2 : int'(bif.SC_PULSETRAIN_PERIOD);
         m_cont = CONT && bif.SC_PULSETRAIN_COUNT == '0;
      end
      @(posedge clk);
      cyc++;
      #1;
      model_eval();
   endtask
   task automatic launch(int c, int p);
      bif.SC_PULSETRAIN_COUNT     = N'(c);
      bif.SC_PULSETRAIN_PERIOD    = P'(p);
      bif.SC_PULSETRAIN_START_InLow = 1'b0;
      tick();
      bif.SC_PULSETRAIN_START_InLow = 1'b1;
      bif.SC_PULSETRAIN_COUNT     = N'($urandom);
      bif.SC_PULSETRAIN_PERIOD    = P'($urandom);
   endtask
   task automatic test_reset();
      #1;
      n_chk++;
      if (obs() !== {3'b011, N'(0)}) $display("FAIL reset_init: got %b want %b", obs(), {3'b011, N'(0)});
      else n_pass++;
      #2 rst = 1'b0;
      model_eval();
      launch(4, 4);
      for (int j = 1; j <= 6; j++) begin
         n_chk++;
         if (obs() !== e_vec) $display("FAIL reset_pre cyc %0d: got %b want %b", j, obs(), e_vec);
         else n_pass++;
         tick();
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (obs() !== {3'b011, N'(0)}) $display("FAIL reset_mid: got %b want %b", obs(), {3'b011, N'(0)});
      else n_pass++;
      #2 rst = 1'b0;
      m_act = 1'b0;
      m_rem = '0;
      model_eval();
      for (int j = 0; j < 4; j++) begin
         tick();
         n_chk++;
         if (obs() !== {3'b011, N'(0)}) $display("FAIL reset_after cyc %0d: got %b want %b", j, obs(), {3'b011, N'(0)});
         else n_pass++;
      end
   endtask
   task automatic test_spec_train();
      int hi = 0;
      int done_at = -1;
      launch(3, 4);
      for (int j = 1; j <= 16; j++) begin
         n_chk++;
         if (obs() !== e_vec) $display("FAIL spec_train cyc t+%0d: got %b want %b", j, obs(), e_vec);
         else n_pass++;
         hi += int'(bif.SC_PULSETRAIN_PULSE_Out);
         if (!bif.SC_PULSETRAIN_DONE_OutLow) done_at = j;
         tick();
      end
      n_chk++;
      if (hi !== 6) $display("FAIL spec_train_hi: got %0d want 6", hi);
      else n_pass++;
      n_chk++;
      if (done_at !== 13) $display("FAIL spec_train_done: got t+%0d want t+13", done_at);
      else n_pass++;
   endtask
   task automatic test_period_edges();
      int pers[2] = '{1, 5};
      int exp_hi[2] = '{2, 4};
      int exp_done[2] = '{5, 11};
      for (int n = 0; n < 2; n++) begin
         int hi = 0;
         int done_at = -1;
         launch(2, pers[n]);
         for (int j = 1; j <= exp_done[n] + 2; j++) begin
            n_chk++;
            if (obs() !== e_vec) $display("FAIL period%0d cyc t+%0d: got %b want %b", pers[n], j, obs(), e_vec);
            else n_pass++;
            hi += int'(bif.SC_PULSETRAIN_PULSE_Out);
            if (!bif.SC_PULSETRAIN_DONE_OutLow) done_at = j;
            tick();
         end
         n_chk++;
         if (hi !== exp_hi[n] || done_at !== exp_done[n])
            $display("FAIL period%0d_shape: got hi %0d done t+%0d want hi %0d done t+%0d",
                     pers[n], hi, done_at, exp_hi[n], exp_done[n]);
         else n_pass++;
      end
   endtask
   task automatic test_count_zero();
      launch(0, 2);
`ifdef PULSETRAIN_CONTINUOUS_EN
      begin
         int hi = 0;
         for (int j = 1; j <= 230; j++) begin
            n_chk++;
            if (obs() !== e_vec) $display("FAIL cont cyc t+%0d: got %b want %b", j, obs(), e_vec);
            else n_pass++;
            hi += int'(bif.SC_PULSETRAIN_PULSE_Out);
            tick();
         end
         n_chk++;
         if (hi < 101) $display("FAIL cont_hi: got %0d want >100", hi);
         else n_pass++;
         bif.SC_PULSETRAIN_ABORT_InLow = 1'b0;
         tick();
         bif.SC_PULSETRAIN_ABORT_InLow = 1'b1;
         n_chk++;
         if (obs() !== {3'b011, N'(0)}) $display("FAIL cont_abort: got %b want %b", obs(), {3'b011, N'(0)});
         else n_pass++;
      end
`else
      n_chk++;
      if (obs() !== {3'b000, N'(0)}) $display("FAIL zero_done: got %b want %b", obs(), {3'b000, N'(0)});
      else n_pass++;
      tick();
      n_chk++;
      if (obs() !== {3'b011, N'(0)}) $display("FAIL zero_idle: got %b want %b", obs(), {3'b011, N'(0)});
      else n_pass++;
`endif
      tick();
   endtask
   task automatic test_abort();
      bit saw_done = 1'b0;
      launch(5, 6);
      for (int j = 1; j <= 14; j++) begin
         n_chk++;
         if (obs() !== e_vec) $display("FAIL abort_pre cyc t+%0d: got %b want %b", j, obs(), e_vec);
         else n_pass++;
         tick();
      end
      bif.SC_PULSETRAIN_ABORT_InLow = 1'b0;
      tick();
      bif.SC_PULSETRAIN_ABORT_InLow = 1'b1;
      for (int j = 0; j < 8; j++) begin
         n_chk++;
         if (obs() !== {3'b011, N'(3)}) $display("FAIL abort_post cyc %0d: got %b want %b", j, obs(), {3'b011, N'(3)});
         else n_pass++;
         saw_done |= !bif.SC_PULSETRAIN_DONE_OutLow;
         tick();
      end
      n_chk++;
      if (saw_done !== 1'b0) $display("FAIL abort_nodone: got %b want 0", saw_done);
      else n_pass++;
   endtask
   task automatic test_ignore_start();
      int done_at = -1;
      launch(2, 3);
      for (int j = 1; j <= 10; j++) begin
         n_chk++;
         if (obs() !== e_vec) $display("FAIL ignore cyc t+%0d: got %b want %b", j, obs(), e_vec);
         else n_pass++;
         if (!bif.SC_PULSETRAIN_DONE_OutLow) done_at = j;
         bif.SC_PULSETRAIN_START_InLow = j < 6 ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      n_chk++;
      if (done_at !== 7) $display("FAIL ignore_done: got t+%0d want t+7", done_at);
      else n_pass++;
      bif.SC_PULSETRAIN_START_InLow = 1'b0;
      bif.SC_PULSETRAIN_ABORT_InLow = 1'b0;
      bif.SC_PULSETRAIN_COUNT = N'(4);
      for (int j = 0; j < 3; j++) begin
         tick();
         n_chk++;
         if (obs() !== {3'b011, N'(0)}) $display("FAIL both_low cyc %0d: got %b want %b", j, obs(), {3'b011, N'(0)});
         else n_pass++;
      end
      bif.SC_PULSETRAIN_START_InLow = 1'b1;
      bif.SC_PULSETRAIN_ABORT_InLow = 1'b1;
      tick();
   endtask
   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         launch($urandom_range(1, 5), $urandom_range(0, 7));
         for (int j = 0; j < 120 && m_act; j++) begin
            n_chk++;
            if (obs() !== e_vec) $display("FAIL random train %0d cyc %0d: got %b want %b", n, j, obs(), e_vec);
            else n_pass++;
            bif.SC_PULSETRAIN_ABORT_InLow = $urandom_range(0, 39) != 0;
            bif.SC_PULSETRAIN_START_InLow = $urandom_range(0, 7) != 0;
            bif.SC_PULSETRAIN_COUNT  = N'($urandom_range(0, 4));
            bif.SC_PULSETRAIN_PERIOD = P'($urandom_range(0, 6));
            tick();
         end
         bif.SC_PULSETRAIN_START_InLow = 1'b1;
         bif.SC_PULSETRAIN_ABORT_InLow = 1'b0;
         tick();
         bif.SC_PULSETRAIN_ABORT_InLow = 1'b1;
         n_chk++;
         if (obs() !== e_vec) $display("FAIL random_end %0d: got %b want %b", n, obs(), e_vec);
         else n_pass++;
      end
   endtask
   initial begin
      bif.SC_PULSETRAIN_START_InLow = 1'b1;
      bif.SC_PULSETRAIN_ABORT_InLow = 1'b1;
      bif.SC_PULSETRAIN_COUNT  = '0;
      bif.SC_PULSETRAIN_PERIOD = '0;
      test_reset();
      test_spec_train();
      test_period_edges();
      test_count_zero();
      test_abort();
      test_ignore_start();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
